ctrl_fsm_param: RTL and testbench

Parametrised multicycle control unit for the 16-bit datapath. It sequences fetch, decode, execute, memory and writeback, and drives every datapath enable and mux select. Over the current fixed controller it adds:
- configurable instruction-fetch latency;
- configurable data-memory latency with a ready handshake;
- illegal-opcode trapping;
- a retired-instruction counter.

It sits between the instruction/PSR registers and the datapath and memory.

---
 rtl/ctrl_fsm_param.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_ctrl_fsm_param.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_fsm_param.sv
// ctrl_fsm_param
// Multicycle control unit for the 16-bit datapath. Sequences fetch, decode,
// execute, memory and writeback and drives every datapath enable and select.
// Fetch and data-memory latencies are parameters. Illegal opcodes are trapped,
// and completed instructions are counted.
//
// Handshake: mem_ready is sampled on the rising clock edge while in LBRD or
// SBWR only. A memory state is left on the first edge where the state has
// been occupied for at least MEM_LAT cycles AND mem_ready is high. Earlier
// ready pulses are ignored. A low mem_ready stalls the state indefinitely, and
// the state's outputs stay asserted for the whole wait.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   opCode1, opCode2, conditionCode   instruction fields
//   PSR               processor status, flags F[4:0] = PSR[4:0]
//   mem_ready         data memory ready
//   PCEN .. JALEN     datapath enables (default 0)
//   zeroExtend, SrcB, updateAddress, writeData   selects (default 1)
//   ALUcontrol, shifterControl, result           mux/control fields
//   illegal           one-cycle pulse when an illegal opcode is trapped
//   retired           count of completed instructions (wraps)
//   state             current state encoding, for debug
module ctrl_fsm_param #(
  parameter int FETCH_LAT = 2,
  parameter int MEM_LAT   = 1,
  parameter int PSR_W     = 8,
  parameter int RETIRE_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          opCode1,
  input  logic [3:0]          opCode2,
  input  logic [3:0]          conditionCode,
  input  logic [PSR_W-1:0]    PSR,
  input  logic                mem_ready,
  output logic                PCEN,
  output logic                PCinstruction,
  output logic                nextInstruction,
  output logic                immediateRegEN,
  output logic                resultEN,
  output logic                PSREN,
  output logic                regWriteEN,
  output logic                wren_a,
  output logic                storeReg,
  output logic                BranchEN,
  output logic                JmpEN,
  output logic                JALEN,
  output logic                zeroExtend,
  output logic                SrcB,
  output logic                updateAddress,
  output logic                writeData,
  output logic [3:0]          ALUcontrol,
  output logic [3:0]          shifterControl,
  output logic [1:0]          result,
  output logic                illegal,
  output logic [RETIRE_W-1:0] retired,
  output logic [4:0]          state
);

  typedef enum logic [4:0] {
    S_FETCH   = 5'h00, S_DECODE  = 5'h01, S_ITYPEEX = 5'h03, S_ITYPEWR = 5'h04,
    S_SHIFTEX = 5'h05, S_SHIFTWR = 5'h06, S_LBRD    = 5'h07, S_LBWR    = 5'h08,
    S_SBWR    = 5'h09, S_RTYPEEX = 5'h0A, S_RTYPEWR = 5'h0B, S_BCONDEX = 5'h0C,
    S_MEMADR  = 5'h0D, S_JALEX   = 5'h0E, S_JALWR   = 5'h0F, S_JCONDEX = 5'h10,
    S_FETCHW  = 5'h11, S_ILLEGAL = 5'h12
  } state_t;

  // The wait counter only ever needs to reach the larger of the two
  // latencies, so it saturates there instead of wrapping during long stalls.
  localparam int CNT_MAX = (FETCH_LAT > MEM_LAT) ? FETCH_LAT : MEM_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(CNT_MAX);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [RETIRE_W-1:0] retired_q, retired_d;
  logic                retire_inc;
  logic [4:0]          f;
  logic                pass;
  logic                mem_done;

  assign f = PSR[4:0];

  if (PSR_W > 5) begin : g_psr_hi
    logic unused_psr_hi;
    assign unused_psr_hi = ^PSR[PSR_W-1:5];
  end

  always_comb begin
    pass = 1'b0;
    case (conditionCode)
      4'h0: pass = f[4];
      4'h1: pass = !f[4];
      4'h2: pass = f[3];
      4'h3: pass = !f[3];
      4'h4: pass = f[0];
      4'h5: pass = !f[0];
      4'h6: pass = f[1];
      4'h7: pass = !f[1];
      4'h8: pass = f[2];
      4'h9: pass = !f[2];
      4'hA: pass = !f[4] && !f[0];
      4'hB: pass = f[4] || f[0];
      4'hC: pass = !f[1] && !f[4];
      4'hD: pass = f[4] || f[1];
      4'hE: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

  // cnt_q counts completed cycles in the current state, so the current cycle
  // is number cnt_q+1 (signed arithmetic keeps MEM_LAT=1 well-formed).
  assign mem_done = ((int'(cnt_q) + 1) >= MEM_LAT) && mem_ready;

  always_comb begin
    state_d         = state_q;
    retire_inc      = 1'b0;
    PCEN            = 1'b0;
    PCinstruction   = 1'b0;
    nextInstruction = 1'b0;
    immediateRegEN  = 1'b0;
    resultEN        = 1'b0;
    PSREN           = 1'b0;
    regWriteEN      = 1'b0;
    wren_a          = 1'b0;
    storeReg        = 1'b0;
    BranchEN        = 1'b0;
    JmpEN           = 1'b0;
    JALEN           = 1'b0;
    zeroExtend      = 1'b1;
    SrcB            = 1'b1;
    updateAddress   = 1'b1;
    writeData       = 1'b1;
    ALUcontrol      = 4'h5;
    shifterControl  = 4'h0;
    result          = 2'h1;
    illegal         = 1'b0;
    case (state_q)
      S_FETCH: begin
        nextInstruction = 1'b1;
        PCinstruction   = 1'b1;
        PCEN            = 1'b1;
        state_d         = (FETCH_LAT == 1) ? S_DECODE : S_FETCHW;
      end
      S_FETCHW: begin
        // FETCH plus FETCH_LAT-1 cycles here give FETCH_LAT fetch cycles.
        nextInstruction = 1'b1;
        if ((int'(cnt_q) + 2) >= FETCH_LAT) state_d = S_DECODE;
      end
      S_DECODE: begin
        immediateRegEN = 1'b1;
        SrcB           = 1'b0;
        zeroExtend     = (opCode1 == 4'h1) || (opCode1 == 4'h2) ||
                         (opCode1 == 4'h3) || (opCode1 == 4'hD);
        case (opCode1)
          4'h0:                                    state_d = S_RTYPEEX;
          4'h4:                                    state_d = S_MEMADR;
          4'h8, 4'hF:                              state_d = S_SHIFTEX;
          4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD: state_d = S_ITYPEEX;
          4'hC:                                    state_d = S_BCONDEX;
          default:                                 state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        case (opCode2)
          4'h0:    state_d = S_LBRD;
          4'h4:    state_d = S_SBWR;
          4'h8:    state_d = S_JALEX;
          4'hA:    state_d = S_JCONDEX;
          default: state_d = S_ILLEGAL;
        endcase
      end
      S_LBRD: begin
        updateAddress = 1'b0;
        if (mem_done) state_d = S_LBWR;
      end
      S_SBWR: begin
        updateAddress = 1'b0;
        storeReg      = 1'b1;
        wren_a        = 1'b1;
        if (mem_done) begin
          state_d    = S_FETCH;
          retire_inc = 1'b1;
        end
      end
      S_LBWR: begin
        writeData  = 1'b0;
        regWriteEN = 1'b1;
        state_d    = S_FETCH;
        retire_inc = 1'b1;
      end
      S_RTYPEEX: begin
        ALUcontrol = opCode2;
        PSREN      = 1'b1;
        resultEN   = 1'b1;
        state_d    = S_RTYPEWR;
      end
      S_RTYPEWR: begin
        regWriteEN = (opCode2 != 4'hB);  // CMP only updates flags
        state_d    = S_FETCH;
        retire_inc = 1'b1;
      end
      S_ITYPEEX: begin
        ALUcontrol = opCode1;
        SrcB       = 1'b0;
        PSREN      = 1'b1;
        resultEN   = 1'b1;
        state_d    = S_ITYPEWR;
      end
      S_ITYPEWR: begin
        regWriteEN = (opCode1 != 4'hB);  // CMPI only updates flags
        state_d    = S_FETCH;
        retire_inc = 1'b1;
      end
      S_SHIFTEX: begin
        result   = 2'h0;
        resultEN = 1'b1;
        if (opCode1 == 4'hF) begin
          // LUI: shift the immediate, selected by the primary opcode
          shifterControl = opCode1;
          SrcB           = 1'b0;
        end else begin
          shifterControl = opCode2;
          SrcB           = (opCode2 == 4'h4);
        end
        state_d = S_SHIFTWR;
      end
      S_SHIFTWR: begin
        regWriteEN = 1'b1;
        state_d    = S_FETCH;
        retire_inc = 1'b1;
      end
      S_BCONDEX: begin
        BranchEN      = pass;
        PCinstruction = 1'b1;
        PCEN          = 1'b1;
        SrcB          = 1'b0;
        state_d       = S_FETCH;
        retire_inc    = 1'b1;
      end
      S_JALEX: begin
        JALEN         = 1'b1;
        PCinstruction = 1'b1;
        PCEN          = 1'b1;
        result        = 2'h3;
        resultEN      = 1'b1;
        state_d       = S_JALWR;
      end
      S_JALWR: begin
        regWriteEN = 1'b1;
        state_d    = S_FETCH;
        retire_inc = 1'b1;
      end
      S_JCONDEX: begin
        JmpEN         = pass;
        PCinstruction = 1'b1;
        PCEN          = 1'b1;
        state_d       = S_FETCH;
        retire_inc    = 1'b1;
      end
      S_ILLEGAL: begin
        illegal = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;  // unused encodings recover to fetch
    endcase
  end

  always_comb begin
    if (state_d != state_q)   cnt_d = '0;
    else if (cnt_q == CNT_SAT) cnt_d = cnt_q;
    else                       cnt_d = cnt_q + 1'b1;
    retired_d = retired_q + {{(RETIRE_W-1){1'b0}}, retire_inc};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retired_q <= retired_d;
    end
  end

  assign retired = retired_q;
  assign state   = state_q;

endmodule

// File: tb/tb_ctrl_fsm_param.sv
module tb_ctrl_fsm_param;
  localparam int FL = 2;
  localparam int ML = 2;
  localparam int RW = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [3:0] opCode1, opCode2, conditionCode;
  logic [7:0] PSR;
  logic       mem_ready;
  logic PCEN, PCinstruction, nextInstruction, immediateRegEN, resultEN, PSREN;
  logic regWriteEN, wren_a, storeReg, BranchEN, JmpEN, JALEN;
  logic zeroExtend, SrcB, updateAddress, writeData, illegal;
  logic [3:0] ALUcontrol, shifterControl;
  logic [1:0] result;
  logic [RW-1:0] retired;
  logic [4:0] state;

  ctrl_fsm_param #(.FETCH_LAT(FL), .MEM_LAT(ML), .PSR_W(8), .RETIRE_W(RW)) dut (
    .clk(clk), .reset(reset), .opCode1(opCode1), .opCode2(opCode2),
    .conditionCode(conditionCode), .PSR(PSR), .mem_ready(mem_ready),
    .PCEN(PCEN), .PCinstruction(PCinstruction), .nextInstruction(nextInstruction),
    .immediateRegEN(immediateRegEN), .resultEN(resultEN), .PSREN(PSREN),
    .regWriteEN(regWriteEN), .wren_a(wren_a), .storeReg(storeReg),
    .BranchEN(BranchEN), .JmpEN(JmpEN), .JALEN(JALEN), .zeroExtend(zeroExtend),
    .SrcB(SrcB), .updateAddress(updateAddress), .writeData(writeData),
    .ALUcontrol(ALUcontrol), .shifterControl(shifterControl), .result(result),
    .illegal(illegal), .retired(retired), .state(state)
  );

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] exp_q[$];
  logic [RW-1:0] exp_ret = '0;
  logic [39:0] last_hist = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic report();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  endtask

  // ---------------- reference model ----------------
  function automatic logic pass_of(input logic [3:0] cc, input logic [7:0] psr);
    logic [4:0] fl;
    fl = psr[4:0];
    case (cc)
      4'h0: return fl[4];
      4'h1: return !fl[4];
      4'h2: return fl[3];
      4'h3: return !fl[3];
      4'h4: return fl[0];
      4'h5: return !fl[0];
      4'h6: return fl[1];
      4'h7: return !fl[1];
      4'h8: return fl[2];
      4'h9: return !fl[2];
      4'hA: return !fl[4] && !fl[0];
      4'hB: return fl[4] || fl[0];
      4'hC: return !fl[1] && !fl[4];
      4'hD: return fl[4] || fl[1];
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Expected per-instruction summary: total cycles, how many cycles each
  // interesting enable is high, the last state before returning to fetch,
  // captured control fields and the retired count afterwards.
  function automatic logic [63:0] model(input logic [3:0] o1, o2, cc, input logic [7:0] psr,
                                        input int rd, input logic [RW-1:0] ret_in,
                                        output logic [RW-1:0] ret_out);
    int cyc, rw, il, wr, tk, ps, pc, re, w;
    logic [4:0] term;
    logic [3:0] alu, sh;
    logic ze, counts;
    logic [63:0] v;
    rw = 0; il = 0; wr = 0; tk = 0; ps = 0; pc = 1; re = 0;
    alu = 4'h0; sh = 4'h0; counts = 1'b1; term = 5'h00;
    ze = (o1 == 4'h1) || (o1 == 4'h2) || (o1 == 4'h3) || (o1 == 4'hD);
    w = (rd + 1 > ML) ? rd + 1 : ML;
    if (o1 == 4'h0) begin
      cyc = FL + 3; rw = (o2 != 4'hB); ps = 1; re = 1; term = 5'h0B; alu = o2;
    end else if (o1 inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD}) begin
      cyc = FL + 3; rw = (o1 != 4'hB); ps = 1; re = 1; term = 5'h04; alu = o1;
    end else if (o1 == 4'h8 || o1 == 4'hF) begin
      cyc = FL + 3; rw = 1; re = 1; term = 5'h06; sh = (o1 == 4'hF) ? 4'hF : o2;
    end else if (o1 == 4'hC) begin
      cyc = FL + 2; tk = pass_of(cc, psr); pc = 2; term = 5'h0C;
    end else if (o1 == 4'h4) begin
      case (o2)
        4'h0: begin cyc = FL + 3 + w; rw = 1; term = 5'h08; end
        4'h4: begin cyc = FL + 2 + w; wr = w; term = 5'h09; end
        4'h8: begin cyc = FL + 4; rw = 1; pc = 2; re = 1; term = 5'h0F; end
        4'hA: begin cyc = FL + 3; tk = pass_of(cc, psr); pc = 2; term = 5'h10; end
        default: begin cyc = FL + 3; il = 1; term = 5'h12; counts = 1'b0; end
      endcase
    end else begin
      cyc = FL + 2; il = 1; term = 5'h12; counts = 1'b0;
    end
    ret_out = ret_in + RW'(counts);
    v = '0;
    v[7:0] = 8'(cyc); v[11:8] = 4'(rw); v[15:12] = 4'(il); v[23:16] = 8'(wr);
    v[27:24] = 4'(tk); v[31:28] = 4'(ps); v[35:32] = 4'(pc); v[39:36] = 4'(re);
    v[44:40] = term; v[48:45] = alu; v[52:49] = sh; v[53] = ze;
    v[54 +: RW] = ret_out;
    return v;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  int m_cyc, m_rw, m_il, m_wr, m_tk, m_ps, m_pc, m_re;
  logic [4:0] m_term;
  logic [3:0] m_alu, m_sh;
  logic m_ze;
  logic m_open = 1'b0;
  logic [39:0] m_hist;

  task automatic m_accum();
    m_cyc++;
    if (regWriteEN) m_rw++;
    if (illegal) m_il++;
    if (wren_a) m_wr++;
    if (BranchEN || JmpEN) m_tk++;
    if (PSREN) begin m_ps++; m_alu = ALUcontrol; end
    if (PCEN) m_pc++;
    if (resultEN) m_re++;
    if (result == 2'h0) m_sh = shifterControl;
    if (immediateRegEN) m_ze = zeroExtend;
    if (state != 5'h00) m_term = state;
    m_hist = {m_hist[34:0], state};
  endtask

  task automatic m_start();
    m_open = 1'b1;
    m_cyc = 0; m_rw = 0; m_il = 0; m_wr = 0; m_tk = 0; m_ps = 0; m_pc = 0; m_re = 0;
    m_term = 5'h00; m_alu = 4'h0; m_sh = 4'h0; m_ze = 1'b0; m_hist = '0;
    m_accum();
  endtask

  task automatic m_close();
    logic [63:0] e;
    last_hist = m_hist;
    if (exp_q.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL unexpected_completion: got state 0x%0h expected no instruction", m_term);
    end else begin
      e = exp_q.pop_front();
      chk("cycles", m_cyc, e[7:0]);
      chk("regwrite_cycles", m_rw, e[11:8]);
      chk("illegal_pulses", m_il, e[15:12]);
      chk("wren_cycles", m_wr, e[23:16]);
      chk("taken_cycles", m_tk, e[27:24]);
      chk("psren_cycles", m_ps, e[31:28]);
      chk("pcen_cycles", m_pc, e[35:32]);
      chk("resulten_cycles", m_re, e[39:36]);
      chk("terminal_state", m_term, e[44:40]);
      chk("alu_control", m_alu, e[48:45]);
      chk("shifter_control", m_sh, e[52:49]);
      chk("zero_extend", m_ze, e[53]);
      chk("retired", retired, e[54 +: RW]);
    end
  endtask

  always @(negedge clk) begin
    if (reset) m_start();  // reset holds FETCH: that cycle opens a new instruction
    else if (state == 5'h00) begin
      if (m_open) m_close();
      m_start();
    end else if (m_open) m_accum();
  end

  // ---------------- driver ----------------
  // Called just after a negedge at which the DUT is in FETCH; returns at the
  // next negedge where the DUT is back in FETCH.
  task automatic issue(input logic [3:0] o1, o2, cc, input logic [7:0] psr, input int rd);
    logic [RW-1:0] nr;
    int k;
    logic done;
    exp_q.push_back(model(o1, o2, cc, psr, rd, exp_ret, nr));
    exp_ret = nr;
    opCode1 = o1; opCode2 = o2; conditionCode = cc; PSR = psr;
    mem_ready = 1'b0;
    k = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      k++;
      if (state == 5'h00) done = 1'b1;
      else if (k > 400) begin
        n_tests++; n_fail++;
        $display("FAIL timeout: got state 0x%0h expected return to fetch", state);
        report();
      end else mem_ready = (k >= FL + 2 + rd);  // ready rises in memory cycle rd+1
    end
  endtask

  initial begin
    logic [3:0] o1, o2;
    reset = 1'b1;
    opCode1 = 4'h0; opCode2 = 4'h0; conditionCode = 4'h0; PSR = 8'h00; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_state", state, 5'h00);
    chk("reset_retired", retired, 0);
    chk("reset_pcen", PCEN, 1);
    chk("reset_regwrite", regWriteEN, 0);
    chk("reset_alu", ALUcontrol, 4'h5);
    chk("reset_result", result, 2'h1);
    #1 reset = 1'b0;

    // directed cases
    issue(4'h0, 4'h5, 4'h0, 8'h00, 0);                   // ADD
    #1 chk("add_trace", last_hist[24:0], {5'h00, 5'h11, 5'h01, 5'h0A, 5'h0B});
    issue(4'h0, 4'hB, 4'h0, 8'h00, 0);                   // CMP
    issue(4'h4, 4'h4, 4'h0, 8'h00, 3);                   // SB, 3 not-ready cycles
    issue(4'hC, 4'h0, 4'hA, 8'h00, 0);                   // branch taken
    issue(4'hC, 4'h0, 4'hA, 8'h01, 0);                   // branch not taken
    issue(4'h6, 4'h0, 4'h0, 8'h00, 0);                   // illegal at decode
    issue(4'h4, 4'h0, 4'h0, 8'h00, 0);                   // LB, ready early
    issue(4'h4, 4'h0, 4'h0, 8'h00, 4);                   // LB, late ready
    issue(4'h4, 4'h8, 4'h0, 8'h00, 0);                   // JAL
    issue(4'h4, 4'hA, 4'hE, 8'h00, 0);                   // JCOND always
    issue(4'h4, 4'h3, 4'h0, 8'h00, 0);                   // illegal at MEMADR
    issue(4'hF, 4'h2, 4'h0, 8'h00, 0);                   // LUI
    issue(4'h8, 4'h4, 4'h0, 8'h00, 0);                   // shift
    issue(4'hB, 4'h0, 4'h0, 8'h00, 0);                   // CMPI
    issue(4'hD, 4'h0, 4'h0, 8'h00, 0);                   // zero-extended I-type

    // randomized instruction stream
    for (int i = 0; i < 150; i++) begin
      o1 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) o1 = 4'h4;
      case ($urandom_range(0, 4))
        0: o2 = 4'h0;
        1: o2 = 4'h4;
        2: o2 = 4'h8;
        3: o2 = 4'hA;
        default: o2 = 4'($urandom_range(0, 15));
      endcase
      issue(o1, o2, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
            $urandom_range(0, 4));
    end

    // asynchronous reset in the middle of a store wait
    opCode1 = 4'h4; opCode2 = 4'h4; mem_ready = 1'b0;
    repeat (FL + 3) @(negedge clk);
    chk("sb_state_before_reset", state, 5'h09);
    chk("sb_wren_before_reset", wren_a, 1);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_state", state, 5'h00);
    chk("async_reset_wren", wren_a, 0);
    chk("async_reset_retired", retired, 0);
    chk("async_reset_pcen", PCEN, 1);
    @(negedge clk);
    #1 reset = 1'b0;
    exp_ret = '0;

    // five completed instructions wrap a 2-bit counter to 1
    for (int i = 0; i < 5; i++) issue(4'h0, 4'h5, 4'h0, 8'h00, 0);
    #1 chk("retired_wrap", retired, 1);

    @(negedge clk);
    #1 chk("queue_empty", exp_q.size(), 0);
    report();
  end

endmodule
